decode_cycle: RTL and testbench
===============================

DECODE_CYCLE -- requirements
Module: decode_cycle

Interface
REQ-001 Parameter REGFILE_RESET, default 1; 1 = all 32 registers cleared by rst, 0 = contents retained through reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 InstrD  input  32  instruction from fetch stage.
REQ-005 PCD  input  32  PC of InstrD.
REQ-006 PCPlus4D  input  32  PCD+4.
REQ-007 RegWriteW  input  1  writeback enable.
REQ-008 RDW  input  5  writeback destination register.
REQ-009 ResultW  input  32  writeback data.
REQ-010 FlushE  input  1  hazard-unit request to turn the ID/EX register into a bubble.
REQ-011 RegWriteE, MemWriteE, ALUSrcE, ResultSrcE, BranchE  output  1 each  registered control; ResultSrcE 1 = memory data.
REQ-012 ALUControlE  output  3  registered ALU op.
REQ-013 RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E  output  32 each  registered operands, immediate, PC values.
REQ-014 RS1_E, RS2_E, RD_E  output  5 each  registered register indices (InstrD[19:15], [24:20], [11:7]).

Function
REQ-015 Register file SHALL hold 32x32 bits, two combinational read ports (rs1, rs2) and one write port written on rising clk when RegWriteW=1 and RDW!=0.
REQ-016 x0 SHALL always read 0; writes to x0 SHALL be ignored.
REQ-017 Same-cycle write/read: if RegWriteW=1, RDW!=0 and RDW equals rs1 (rs2), the read port SHALL return ResultW (write-before-read bypass).
REQ-018 Decode by opcode InstrD[6:0]: 0000011 lw: RegWrite=1, ALUSrc=1, ResultSrc=1, I-imm, ALU add; 0100011 sw: MemWrite=1, ALUSrc=1, S-imm, add; 0110011 R-type: RegWrite=1, ALU per REQ-019; 0010011 I-ALU: RegWrite=1, ALUSrc=1, I-imm, ALU per REQ-019; 1100011 beq: Branch=1, B-imm, ALU sub.
REQ-019 ALU field: funct3 000 -> sub (001) only when R-type and InstrD[30]=1, else add (000); 010 -> slt (101); 110 -> or (011); 111 -> and (010); any other funct3 -> add (000).
REQ-020 Unsupported opcode SHALL produce all control signals 0 and ALUControl 000 (bubble); datapath fields still captured.
REQ-021 Immediates SHALL be sign-extended from InstrD[31]: I = [31:20]; S = {[31:25],[11:7]}; B = {[31],[7],[30:25],[11:8],0}; opcodes without immediate -> 0.
REQ-022 Latency: one cycle; values decoded from D inputs before edge k SHALL appear on all E outputs after edge k; no combinational path from D inputs to E outputs.
REQ-023 FlushE=1 at an edge SHALL load all E outputs with 0 (full bubble), regardless of InstrD.
REQ-024 rst SHALL take priority over FlushE and over a simultaneous register-file write.

Reset
REQ-025 rst=1 at an edge SHALL set every E output to 0 and, with REGFILE_RESET=1, all 32 registers to 0.
REQ-026 Reset mid-operation SHALL discard the instruction in flight; first valid decode occurs at the first edge after rst deasserts.

Verification
REQ-027 rst=1 for 2 cycles -> every E output 0; subsequent read of any register via add rd,rsX,x0 gives RD1_E=0.
REQ-028 Write x5=0xDEADBEEF (RegWriteW=1, RDW=5), next cycle InstrD=0x00028333 (add x6,x5,x0) -> RD1_E=0xDEADBEEF, RegWriteE=1, RD_E=6, ALUControlE=000, ALUSrcE=0.
REQ-029 Same cycle RegWriteW=1, RDW=7, ResultW=0x12345678, InstrD=0xFFF38413 (addi x8,x7,-1) -> RD1_E=0x12345678, Imm_Ext_E=0xFFFFFFFF, ALUSrcE=1, RD_E=8.
REQ-030 RegWriteW=1, RDW=0, ResultW=0x0000FFFF, then read x0 -> RD1_E=0.
REQ-031 InstrD=0xFE208CE3 (beq x1,x2,-8), PCD=0x100 -> BranchE=1, ALUControlE=001, Imm_Ext_E=0xFFFFFFF8, PCE=0x100, RegWriteE=0.
REQ-032 sw instruction with FlushE=1 -> all E outputs 0; FlushE=1 and rst=1 together with RegWriteW=1, RDW=3 -> all E 0 and x3 reads 0.

Source files
------------

// File: rtl/decode_cycle.sv
// Decode stage of a five-stage RV32I subset pipeline: register file with
// write-before-read bypass, main/ALU decoder, immediate generator and ID/EX register.
module decode_cycle #(
   parameter int unsigned REGFILE_RESET = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] InstrD,
   input  logic [31:0] PCD,
   input  logic [31:0] PCPlus4D,
   input  logic        RegWriteW,
   input  logic [4:0]  RDW,
   input  logic [31:0] ResultW,
   input  logic        FlushE,
   output logic        RegWriteE,
   output logic        MemWriteE,
   output logic        ALUSrcE,
   output logic        ResultSrcE,
   output logic        BranchE,
   output logic [2:0]  ALUControlE,
   output logic [31:0] RD1_E,
   output logic [31:0] RD2_E,
   output logic [31:0] Imm_Ext_E,
   output logic [31:0] PCE,
   output logic [31:0] PCPlus4E,
   output logic [4:0]  RS1_E,
   output logic [4:0]  RS2_E,
   output logic [4:0]  RD_E
);

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   typedef enum logic [1:0] {
      IMM_NONE,
      IMM_I,
      IMM_S,
      IMM_B
   } imm_sel_t;

   typedef struct packed {
      logic        reg_write;
      logic        mem_write;
      logic        alu_src;
      logic        result_src;
      logic        branch;
      logic [2:0]  alu_control;
      logic [31:0] rd1;
      logic [31:0] rd2;
      logic [31:0] imm_ext;
      logic [31:0] pc;
      logic [31:0] pc_plus4;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
   } id_ex_t;

   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [4:0]  rs1_addr;
   logic [4:0]  rs2_addr;
   logic [4:0]  rd_addr;

   logic [31:0] regs_q [32];
   logic [31:0] regs_d [32];
   logic        wb_active;
   logic [31:0] rd1_data;
   logic [31:0] rd2_data;

   logic        dec_reg_write;
   logic        dec_mem_write;
   logic        dec_alu_src;
   logic        dec_result_src;
   logic        dec_branch;
   logic        dec_alu_from_funct;
   logic [2:0]  dec_alu_control;
   imm_sel_t    dec_imm_sel;
   logic [31:0] imm_ext;

   id_ex_t      id_ex_d;
   id_ex_t      id_ex_q;

   assign opcode   = InstrD[6:0];
   assign funct3   = InstrD[14:12];
   assign rs1_addr = InstrD[19:15];
   assign rs2_addr = InstrD[24:20];
   assign rd_addr  = InstrD[11:7];

   assign wb_active = RegWriteW && (RDW != 5'd0);

   always_comb begin
      regs_d = regs_q;
      if (wb_active) begin
         regs_d[RDW] = ResultW;
      end
      regs_d[0] = 32'd0;
   end

   // Reset blocks writeback; with REGFILE_RESET=0 the contents simply hold.
   always_ff @(posedge clk) begin
      if (rst) begin
         if (REGFILE_RESET != 0) begin
            for (int i = 0; i < 32; i++) begin
               regs_q[i] <= 32'd0;
            end
         end
      end else begin
         regs_q <= regs_d;
      end
   end

   // Writeback data is forwarded so a same-cycle read sees the new value.
   always_comb begin
      rd1_data = regs_q[rs1_addr];
      rd2_data = regs_q[rs2_addr];
      if (wb_active && (RDW == rs1_addr)) begin
         rd1_data = ResultW;
      end
      if (wb_active && (RDW == rs2_addr)) begin
         rd2_data = ResultW;
      end
      if (rs1_addr == 5'd0) begin
         rd1_data = 32'd0;
      end
      if (rs2_addr == 5'd0) begin
         rd2_data = 32'd0;
      end
   end

   always_comb begin
      dec_reg_write      = 1'b0;
      dec_mem_write      = 1'b0;
      dec_alu_src        = 1'b0;
      dec_result_src     = 1'b0;
      dec_branch         = 1'b0;
      dec_alu_from_funct = 1'b0;
      dec_imm_sel        = IMM_NONE;
      case (opcode)
         OP_LOAD: begin
            dec_reg_write  = 1'b1;
            dec_alu_src    = 1'b1;
            dec_result_src = 1'b1;
            dec_imm_sel    = IMM_I;
         end
         OP_STORE: begin
            dec_mem_write = 1'b1;
            dec_alu_src   = 1'b1;
            dec_imm_sel   = IMM_S;
         end
         OP_RTYPE: begin
            dec_reg_write      = 1'b1;
            dec_alu_from_funct = 1'b1;
         end
         OP_ITYPE: begin
            dec_reg_write      = 1'b1;
            dec_alu_src        = 1'b1;
            dec_alu_from_funct = 1'b1;
            dec_imm_sel        = IMM_I;
         end
         OP_BRANCH: begin
            dec_branch  = 1'b1;
            dec_imm_sel = IMM_B;
         end
         default: begin
            dec_reg_write = 1'b0;
         end
      endcase
   end

   // InstrD[30] selects sub only for R-type; for I-type it is immediate bit 10.
   always_comb begin
      dec_alu_control = ALU_ADD;
      if (opcode == OP_BRANCH) begin
         dec_alu_control = ALU_SUB;
      end else if (dec_alu_from_funct) begin
         case (funct3)
            3'b000: begin
               if ((opcode == OP_RTYPE) && InstrD[30]) begin
                  dec_alu_control = ALU_SUB;
               end
            end
            3'b010:  dec_alu_control = ALU_SLT;
            3'b110:  dec_alu_control = ALU_OR;
            3'b111:  dec_alu_control = ALU_AND;
            default: dec_alu_control = ALU_ADD;
         endcase
      end
   end

   always_comb begin
      imm_ext = 32'd0;
      case (dec_imm_sel)
         IMM_I:   imm_ext = {{20{InstrD[31]}}, InstrD[31:20]};
         IMM_S:   imm_ext = {{20{InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
         IMM_B:   imm_ext = {{20{InstrD[31]}}, InstrD[7], InstrD[30:25],
                             InstrD[11:8], 1'b0};
         default: imm_ext = 32'd0;
      endcase
   end

   always_comb begin
      id_ex_d = '0;
      if (!FlushE) begin
         id_ex_d.reg_write   = dec_reg_write;
         id_ex_d.mem_write   = dec_mem_write;
         id_ex_d.alu_src     = dec_alu_src;
         id_ex_d.result_src  = dec_result_src;
         id_ex_d.branch      = dec_branch;
         id_ex_d.alu_control = dec_alu_control;
         id_ex_d.rd1         = rd1_data;
         id_ex_d.rd2         = rd2_data;
         id_ex_d.imm_ext     = imm_ext;
         id_ex_d.pc          = PCD;
         id_ex_d.pc_plus4    = PCPlus4D;
         id_ex_d.rs1         = rs1_addr;
         id_ex_d.rs2         = rs2_addr;
         id_ex_d.rd          = rd_addr;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         id_ex_q <= '0;
      end else begin
         id_ex_q <= id_ex_d;
      end
   end

   assign RegWriteE   = id_ex_q.reg_write;
   assign MemWriteE   = id_ex_q.mem_write;
   assign ALUSrcE     = id_ex_q.alu_src;
   assign ResultSrcE  = id_ex_q.result_src;
   assign BranchE     = id_ex_q.branch;
   assign ALUControlE = id_ex_q.alu_control;
   assign RD1_E       = id_ex_q.rd1;
   assign RD2_E       = id_ex_q.rd2;
   assign Imm_Ext_E   = id_ex_q.imm_ext;
   assign PCE         = id_ex_q.pc;
   assign PCPlus4E    = id_ex_q.pc_plus4;
   assign RS1_E       = id_ex_q.rs1;
   assign RS2_E       = id_ex_q.rs2;
   assign RD_E        = id_ex_q.rd;

endmodule

// File: tb/tb_decode_cycle.sv
// Directed bench for decode_cycle: each step queues its expected ID/EX contents,
// which are popped and compared one cycle later.
module tb_decode_cycle;

   logic        clk;
   logic        rst;
   logic [31:0] InstrD;
   logic [31:0] PCD;
   logic [31:0] PCPlus4D;
   logic        RegWriteW;
   logic [4:0]  RDW;
   logic [31:0] ResultW;
   logic        FlushE;
   logic        RegWriteE;
   logic        MemWriteE;
   logic        ALUSrcE;
   logic        ResultSrcE;
   logic        BranchE;
   logic [2:0]  ALUControlE;
   logic [31:0] RD1_E;
   logic [31:0] RD2_E;
   logic [31:0] Imm_Ext_E;
   logic [31:0] PCE;
   logic [31:0] PCPlus4E;
   logic [4:0]  RS1_E;
   logic [4:0]  RS2_E;
   logic [4:0]  RD_E;

   typedef struct packed {
      logic        rw;
      logic        mw;
      logic        as;
      logic        rs;
      logic        br;
      logic [2:0]  alu;
      logic [31:0] rd1;
      logic [31:0] rd2;
      logic [31:0] imm;
      logic [31:0] pc;
      logic [31:0] pcp4;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
   } exp_t;

   exp_t        sb[$];
   int          total;
   int          bad;
   logic [31:0] pc;

   decode_cycle #(.REGFILE_RESET(1)) dut (
      .clk(clk), .rst(rst), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
      .RegWriteW(RegWriteW), .RDW(RDW), .ResultW(ResultW), .FlushE(FlushE),
      .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ALUSrcE(ALUSrcE),
      .ResultSrcE(ResultSrcE), .BranchE(BranchE), .ALUControlE(ALUControlE),
      .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_Ext_E(Imm_Ext_E), .PCE(PCE),
      .PCPlus4E(PCPlus4E), .RS1_E(RS1_E), .RS2_E(RS2_E), .RD_E(RD_E)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   // ctl = {RegWrite, MemWrite, ALUSrc, ResultSrc, Branch}
   function automatic exp_t mk(input logic [4:0] ctl, input logic [2:0] alu,
                               input logic [31:0] rd1, input logic [31:0] rd2,
                               input logic [31:0] imm);
      exp_t e;
      e     = '0;
      e.rw  = ctl[4];
      e.mw  = ctl[3];
      e.as  = ctl[2];
      e.rs  = ctl[1];
      e.br  = ctl[0];
      e.alu = alu;
      e.rd1 = rd1;
      e.rd2 = rd2;
      e.imm = imm;
      return e;
   endfunction

   task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic checkOutput();
      exp_t e;
      total++;
      assert (sb.size() != 0)
      else begin
         bad++;
         $error("[TB] FAIL scoreboard observed=empty expected=entry");
      end
      if (sb.size() != 0) begin
         e = sb.pop_front();
         cmp("RegWriteE",   {31'd0, RegWriteE},  {31'd0, e.rw});
         cmp("MemWriteE",   {31'd0, MemWriteE},  {31'd0, e.mw});
         cmp("ALUSrcE",     {31'd0, ALUSrcE},    {31'd0, e.as});
         cmp("ResultSrcE",  {31'd0, ResultSrcE}, {31'd0, e.rs});
         cmp("BranchE",     {31'd0, BranchE},    {31'd0, e.br});
         cmp("ALUControlE", {29'd0, ALUControlE}, {29'd0, e.alu});
         cmp("RD1_E",       RD1_E,     e.rd1);
         cmp("RD2_E",       RD2_E,     e.rd2);
         cmp("Imm_Ext_E",   Imm_Ext_E, e.imm);
         cmp("PCE",         PCE,       e.pc);
         cmp("PCPlus4E",    PCPlus4E,  e.pcp4);
         cmp("RS1_E",       {27'd0, RS1_E}, {27'd0, e.rs1});
         cmp("RS2_E",       {27'd0, RS2_E}, {27'd0, e.rs2});
         cmp("RD_E",        {27'd0, RD_E},  {27'd0, e.rd});
      end
   endtask

   task automatic applyStimulus(input logic [31:0] instr, input logic wEn,
                                input logic [4:0] wRd, input logic [31:0] wData,
                                input logic flush, input logic rstIn, input exp_t e);
      InstrD    = instr;
      RegWriteW = wEn;
      RDW       = wRd;
      ResultW   = wData;
      FlushE    = flush;
      rst       = rstIn;
      PCD       = pc;
      PCPlus4D  = pc + 32'd4;
      if (!flush && !rstIn) begin
         e.pc   = pc;
         e.pcp4 = pc + 32'd4;
         e.rs1  = instr[19:15];
         e.rs2  = instr[24:20];
         e.rd   = instr[11:7];
      end
      sb.push_back(e);
      pc = pc + 32'h10;
      @(posedge clk);
      #1;
      checkOutput();
      @(negedge clk);
   endtask

   initial begin
      total     = 0;
      bad       = 0;
      pc        = 32'h0000_1000;
      rst       = 1'b1;
      InstrD    = 32'd0;
      PCD       = 32'd0;
      PCPlus4D  = 32'd0;
      RegWriteW = 1'b0;
      RDW       = 5'd0;
      ResultW   = 32'd0;
      FlushE    = 1'b0;
      @(negedge clk);

      $display("[TB] reset for two cycles, writeback attempted during reset");
      applyStimulus(32'h0082A183, 1'b1, 5'd9, 32'h5555_AAAA, 1'b0, 1'b1, '0);
      applyStimulus(32'h0082A183, 1'b1, 5'd9, 32'h5555_AAAA, 1'b0, 1'b1, '0);

      $display("[TB] read x9 after reset");
      applyStimulus(32'h00048533, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0,
                    mk(5'b10000, 3'b000, 32'd0, 32'd0, 32'd0));

      $display("[TB] write x5 then add x6,x5,x0");
      applyStimulus(32'h00000000, 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 1'b0,
                    mk(5'b00000, 3'b000, 32'd0, 32'd0, 32'd0));
      applyStimulus(32'h00028333, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0,
                    mk(5'b10000, 3'b000, 32'hDEAD_BEEF, 32'd0, 32'd0));

      $display("[TB] same-cycle write x7 with addi x8,x7,-1");
      applyStimulus(32'hFFF38413, 1'b1, 5'd7, 32'h1234_5678, 1'b0, 1'b0,
                    mk(5'b10100, 3'b000, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF));
      applyStimulus(32'h005380B3, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0,
                    mk(5'b10000, 3'b000, 32'h1234_5678, 32'hDEAD_BEEF, 32'd0));

      $display("[TB] write to x0 ignored");
      applyStimulus(32'h000000B3, 1'b1, 5'd0, 32'h0000_FFFF, 1'b0, 1'b0,
                    mk(5'b10000, 3'b000, 32'd0, 32'd0, 32'd0));
      applyStimulus(32'h000000B3, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0,
                    mk(5'b10000, 3'b000, 32'd0, 32'd0, 32'd0));

      $display("[TB] beq x1,x2,-8 at PC 0x100");
      pc = 32'h0000_0100;
      applyStimulus(32'hFE208CE3, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0,
                    mk(5'b00001, 3'b001, 32'd0, 32'd0, 32'hFFFF_FFF8));

      $display("[TB] load, store and ALU decode patterns");
      applyStimulus(32'h0082A183, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0,
                    mk(5'b10110, 3'b000, 32'hDEAD_BEEF, 32'd0, 32'h0000_0008));
      applyStimulus(32'hFE53AE23, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0,
                    mk(5'b01100, 3'b000, 32'h1234_5678, 32'hDEAD_BEEF, 32'hFFFF_FFFC));
      applyStimulus(32'h40538233, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0,
                    mk(5'b10000, 3'b001, 32'h1234_5678, 32'hDEAD_BEEF, 32'd0));
      applyStimulus(32'h40038213, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0,
                    mk(5'b10100, 3'b000, 32'h1234_5678, 32'd0, 32'h0000_0400));
      applyStimulus(32'h0053A233, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0,
                    mk(5'b10000, 3'b101, 32'h1234_5678, 32'hDEAD_BEEF, 32'd0));
      applyStimulus(32'h0053E233, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0,
                    mk(5'b10000, 3'b011, 32'h1234_5678, 32'hDEAD_BEEF, 32'd0));
      applyStimulus(32'h0F03F213, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0,
                    mk(5'b10100, 3'b010, 32'h1234_5678, 32'd0, 32'h0000_00F0));
      applyStimulus(32'h00539233, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0,
                    mk(5'b10000, 3'b000, 32'h1234_5678, 32'hDEAD_BEEF, 32'd0));

      $display("[TB] unsupported opcode becomes a bubble with fields captured");
      applyStimulus(32'h123452B7, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0,
                    mk(5'b00000, 3'b000, 32'd0, 32'd0, 32'd0));

      $display("[TB] rs2 bypass from writeback");
      applyStimulus(32'h009000B3, 1'b1, 5'd9, 32'hCAFE_F00D, 1'b0, 1'b0,
                    mk(5'b10000, 3'b000, 32'd0, 32'hCAFE_F00D, 32'd0));

      $display("[TB] flush of a store");
      applyStimulus(32'hFE53AE23, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, '0);

      $display("[TB] flush plus reset with simultaneous write to x3");
      applyStimulus(32'hFE53AE23, 1'b1, 5'd3, 32'hAAAA_5555, 1'b1, 1'b1, '0);
      applyStimulus(32'h005180B3, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0,
                    mk(5'b10000, 3'b000, 32'd0, 32'd0, 32'd0));

      total++;
      assert (sb.size() == 0)
      else begin
         bad++;
         $error("[TB] FAIL scoreboard_drain observed=%0d expected=0", sb.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
